seq_ctrl: RTL and testbench
===========================

// Module: seq_ctrl
// PURPOSE
//  Programmable controller for arbitrary-sequence counting. Holds a writable
//  table of up to DEPTH values and steps through them on command.
//  Supports one-shot or looping playback, with hold, stop and restart.
//  Replaces hard-coded case-based sequence counters. Software or a host FSM
//  programs the table, then issues start/stop.
// PARAMETERS
//  WIDTH       4  bit width of each sequence value / count output
//  DEPTH       8  number of table entries (power of 2, >=2)
//  AW          3  index width, = $clog2(DEPTH)
//  PRESCALE_W  8  prescaler width (used only with SEQ_CTRL_PRESCALE_EN)
// PORTS
//  clk       in   1           clock, all logic on posedge
//  rst_n     in   1           synchronous reset, active-low
//  cfg_we    in   1           table write strobe
//  cfg_addr  in   AW          table write address
//  cfg_data  in   WIDTH       table write data
//  cfg_len   in   AW          index of last entry in sequence, sampled at start
//  loop_en   in   1           1: wrap to entry 0 after last; 0: one-shot
//  start     in   1           begin/restart playback at entry 0 (pulse)
//  stop      in   1           abort playback (pulse)
//  hold      in   1           level; freeze playback while high
//  count     out  WIDTH       current sequence value
//  idx       out  AW          table index of current value
//  busy      out  1           1 while state RUN
//  done      out  1           1-cycle pulse at one-shot completion
//  cfg_err   out  1           1-cycle pulse: write attempted while busy
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): count=0, idx=0, busy=0, done=0, cfg_err=0,
//   len_q=0, all table entries=0, state=IDLE. Applies mid-run too.
//  States: IDLE, RUN. Command priority per cycle: stop > start > hold > advance.
//  IDLE: count/idx hold their last values. start -> RUN.
//   On the next edge: len_q=cfg_len, idx=0, count=table[0], busy=1.
//  RUN, per advance tick (every cycle when hold=0):
//   - idx<len_q: idx+1, count=table[idx+1].
//   - idx==len_q, loop_en=1: idx=0, count=table[0].
//   - idx==len_q, loop_en=0: go to IDLE with busy=0 and a done pulse this edge;
//     count and idx hold the last entry.
//  loop_en is sampled live at each wrap decision.
//  hold=1 in RUN: count, idx and prescale counter are frozen. No done pulse.
//  stop in RUN: go to IDLE next edge, busy=0, no done, count/idx hold.
//   stop in IDLE is a no-op.
//  start in RUN (without stop): restart at entry 0 with a new len_q.
//   No done pulse.
//  stop and start in the same cycle: stop wins, end in IDLE.
//  cfg_len=0: single-entry sequence. Looping repeats table[0].
//   One-shot gives done one tick after start.
//  cfg_we while busy=0: table[cfg_addr]<=cfg_data, visible next cycle.
//   A same-cycle start reads the OLD entry.
//  cfg_we while busy=1: write dropped, cfg_err=1 for one cycle.
//  Entries beyond len_q are never output. idx never exceeds len_q.
// CONFIGURATION
//  SEQ_CTRL_PRESCALE_EN defined: adds input port prescale [PRESCALE_W].
//   An advance tick occurs every prescale+1 cycles in RUN, so each value is
//   held prescale+1 cycles. The divider clears on start and on entry to RUN.
//   prescale is sampled at start.
//  SEQ_CTRL_PRESCALE_EN undefined: no prescale port, advance every RUN cycle.
// TESTING
//  1 Write 2,9,4,1,6,3,8 to addr 0..6, cfg_len=6, loop_en=1, start pulse
//    -> count 2,9,4,1,6,3,8,2,9... one value per cycle from the edge after
//    start; busy=1 throughout.
//  2 Table 5,A,F, cfg_len=2, loop_en=0, start -> count 5,A,F.
//    The next edge gives done=1 for 1 cycle, busy=0, count stays F, idx=2.
//  3 Loop of test 1. Assert hold for 3 cycles while count=1 (idx=3)
//    -> count=1 for 4 cycles total, then 6,3,8.
//  4 cfg_we addr0 data=7 while busy -> cfg_err pulse. On wrap, count=2 (not 7).
//    stop, write again -> no err; start -> count=7.
//  5 rst_n=0 for 1 cycle mid-run -> count=0, idx=0, busy=0.
//    Separately: stop and start in the same cycle -> IDLE, busy=0.
//  6 With SEQ_CTRL_PRESCALE_EN, prescale=2, test 1 table
//    -> each value held exactly 3 cycles: 2,2,2,9,9,9,...

Source files
------------

// File: rtl/seq_ctrl_if.sv
// Host-side command/config bundle and status returns for seq_ctrl.
// SEQ_CTRL_PRESCALE_EN adds the prescale field.
interface seq_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int AW    = 3
`ifdef SEQ_CTRL_PRESCALE_EN
   ,parameter int PRESCALE_W = 8
`endif
);
   logic             cfg_we;
   logic [AW-1:0]    cfg_addr;
   logic [WIDTH-1:0] cfg_data;
   logic [AW-1:0]    cfg_len;
   logic             loop_en;
   logic             start;
   logic             stop;
   logic             hold;
   logic [WIDTH-1:0] count;
   logic [AW-1:0]    idx;
   logic             busy;
   logic             done;
   logic             cfg_err;
`ifdef SEQ_CTRL_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale;
`endif

   modport master (
`ifdef SEQ_CTRL_PRESCALE_EN
      output prescale,
`endif
      output cfg_we, cfg_addr, cfg_data, cfg_len, loop_en, start, stop, hold,
      input  count, idx, busy, done, cfg_err
   );

   modport slave (
`ifdef SEQ_CTRL_PRESCALE_EN
      input  prescale,
`endif
      input  cfg_we, cfg_addr, cfg_data, cfg_len, loop_en, start, stop, hold,
      output count, idx, busy, done, cfg_err
   );
endinterface

// File: rtl/seq_ctrl.sv
// Table-driven sequence player: steps a writable value table in one-shot or loop mode.
// Define SEQ_CTRL_PRESCALE_EN to hold each value for prescale+1 cycles.
module seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
`ifdef SEQ_CTRL_PRESCALE_EN
   ,parameter int PRESCALE_W = 8
`endif
) (
   input  logic      clk,
   input  logic      rst_n,
   seq_ctrl_if.slave bus
);
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

   localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0] IDX_ONE  = AW'(1'b1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] tbl_q [DEPTH];
   logic [WIDTH-1:0] count_q, count_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [AW-1:0]    len_q, len_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             tick_s;
   logic             wr_ok_s;
   logic [AW-1:0]    idx_inc_s;

`ifdef SEQ_CTRL_PRESCALE_EN
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [PRESCALE_W-1:0] psc_q, psc_d;
   assign tick_s = (pre_q == psc_q);
`else
   assign tick_s = 1'b1;
`endif

   assign wr_ok_s   = bus.cfg_we && !busy_q;
   assign idx_inc_s = idx_q + IDX_ONE;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!bus.stop && bus.start) state_d = S_RUN;
            else                        state_d = S_IDLE;
         end
         S_RUN: begin
            if (bus.stop)       state_d = S_IDLE;
            else if (bus.start) state_d = S_RUN;
            else if (!bus.hold && tick_s && !(idx_q < len_q) && !bus.loop_en)
                                state_d = S_IDLE;
            else                state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values; stop only changes state, so count/idx hold.
   always_comb begin
      count_d = count_q;
      idx_d   = idx_q;
      len_d   = len_q;
      done_d  = 1'b0;
      err_d   = bus.cfg_we && busy_q;
      busy_d  = (state_d == S_RUN);
`ifdef SEQ_CTRL_PRESCALE_EN
      pre_d   = pre_q;
      psc_d   = psc_q;
`endif
      if (bus.stop) begin
         count_d = count_q;
      end else if (bus.start) begin
         len_d   = bus.cfg_len;
         idx_d   = IDX_ZERO;
         count_d = tbl_q[0];
`ifdef SEQ_CTRL_PRESCALE_EN
         pre_d   = {PRESCALE_W{1'b0}};
         psc_d   = bus.prescale;
`endif
      end else if (state_q == S_RUN && !bus.hold) begin
         if (tick_s) begin
`ifdef SEQ_CTRL_PRESCALE_EN
            pre_d = {PRESCALE_W{1'b0}};
`endif
            if (idx_q < len_q) begin
               idx_d   = idx_inc_s;
               count_d = tbl_q[idx_inc_s];
            end else if (bus.loop_en) begin
               idx_d   = IDX_ZERO;
               count_d = tbl_q[0];
            end else begin
               done_d  = 1'b1;
            end
         end else begin
`ifdef SEQ_CTRL_PRESCALE_EN
            pre_d = pre_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
`endif
            done_d = 1'b0;
         end
      end else begin
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= {WIDTH{1'b0}};
         idx_q   <= IDX_ZERO;
         len_q   <= IDX_ZERO;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef SEQ_CTRL_PRESCALE_EN
         pre_q   <= {PRESCALE_W{1'b0}};
         psc_q   <= {PRESCALE_W{1'b0}};
`endif
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef SEQ_CTRL_PRESCALE_EN
         pre_q   <= pre_d;
         psc_q   <= psc_d;
`endif
         if (wr_ok_s) tbl_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   assign bus.count   = count_q;
   assign bus.idx     = idx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: expectations queued at drive time, compared after each edge.
module tb_seq_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_ctrl_if #(.WIDTH(4), .AW(3)
`ifdef SEQ_CTRL_PRESCALE_EN
      , .PRESCALE_W(8)
`endif
   ) bus ();

   seq_ctrl #(.WIDTH(4), .DEPTH(8), .AW(3)
`ifdef SEQ_CTRL_PRESCALE_EN
      , .PRESCALE_W(8)
`endif
   ) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   typedef struct {
      string tag;
      int    cnt;
      int    ix;
      int    bz;
      int    dn;
      int    er;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   t1_tab [7] = '{2, 9, 4, 1, 6, 3, 8};

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pops one expectation per clock edge and compares every output.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check_val({e.tag, ".count"},   int'(bus.count),   e.cnt);
         check_val({e.tag, ".idx"},     int'(bus.idx),     e.ix);
         check_val({e.tag, ".busy"},    int'(bus.busy),    e.bz);
         check_val({e.tag, ".done"},    int'(bus.done),    e.dn);
         check_val({e.tag, ".cfg_err"}, int'(bus.cfg_err), e.er);
      end
   end

   // Queue the outputs expected after the next edge, then clear pulse inputs.
   task automatic step(input string tag, input int c, input int i, input int b,
                       input int d, input int e);
      exp_t x;
      x.tag = tag; x.cnt = c; x.ix = i; x.bz = b; x.dn = d; x.er = e;
      sb_q.push_back(x);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.cfg_we = 1'b0;
   endtask

   task automatic wr(input string tag, input int a, input int v,
                     input int c, input int i);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(a);
      bus.cfg_data = 4'(v);
      step(tag, c, i, 0, 0, 0);
   endtask

   task automatic go(input int len, input bit lp);
      bus.cfg_len = 3'(len);
      bus.loop_en = lp;
      bus.start   = 1'b1;
   endtask

   initial begin
      bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_data = 4'd0;
      bus.cfg_len = 3'd0; bus.loop_en = 1'b0; bus.start = 1'b0;
      bus.stop = 1'b0; bus.hold = 1'b0;
`ifdef SEQ_CTRL_PRESCALE_EN
      bus.prescale = 8'd0;
`endif
      @(negedge clk);
      step("rst", 0, 0, 0, 0, 0);
      step("rst", 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Looping playback of the seven-entry table.
      for (int a = 0; a < 7; a++) wr("t1_wr", a, t1_tab[a], 0, 0);
      go(6, 1'b1);
      for (int k = 0; k < 18; k++) step("t1", t1_tab[k % 7], k % 7, 1, 0, 0);

      // Hold while count=1 at idx 3.
      bus.hold = 1'b1;
      for (int k = 0; k < 3; k++) step("t3_hold", 1, 3, 1, 0, 0);
      bus.hold = 1'b0;
      for (int k = 4; k < 8; k++) step("t3", t1_tab[k % 7], k % 7, 1, 0, 0);

      // Write while busy is dropped and flagged.
      bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 4'd7;
      step("t4_err", 9, 1, 1, 0, 1);
      for (int k = 2; k < 8; k++) step("t4", t1_tab[k % 7], k % 7, 1, 0, 0);
      bus.stop = 1'b1;
      step("t4_stop", 2, 0, 0, 0, 0);
      wr("t4_wr", 0, 7, 2, 0);
      go(6, 1'b1);
      step("t4_new", 7, 0, 1, 0, 0);
      step("t4_new", 9, 1, 1, 0, 0);

      // stop beats start, in RUN and in IDLE.
      bus.stop = 1'b1; bus.start = 1'b1;
      step("t5_ss_run", 9, 1, 0, 0, 0);
      bus.stop = 1'b1; bus.start = 1'b1;
      step("t5_ss_idle", 9, 1, 0, 0, 0);

      // One-shot three-entry sequence.
      wr("t2_wr", 0, 5, 9, 1);
      wr("t2_wr", 1, 10, 9, 1);
      wr("t2_wr", 2, 15, 9, 1);
      go(2, 1'b0);
      step("t2", 5, 0, 1, 0, 0);
      step("t2", 10, 1, 1, 0, 0);
      step("t2", 15, 2, 1, 0, 0);
      step("t2_done", 15, 2, 0, 1, 0);
      step("t2_after", 15, 2, 0, 0, 0);

      // Single-entry sequences: one-shot, then loop ended by live loop_en drop.
      go(0, 1'b0);
      step("len0_os", 5, 0, 1, 0, 0);
      step("len0_done", 5, 0, 0, 1, 0);
      go(0, 1'b1);
      for (int k = 0; k < 3; k++) step("len0_loop", 5, 0, 1, 0, 0);
      bus.loop_en = 1'b0;
      step("len0_end", 5, 0, 0, 1, 0);

      // Restart in RUN gives no done pulse.
      go(2, 1'b1);
      step("rs", 5, 0, 1, 0, 0);
      step("rs", 10, 1, 1, 0, 0);
      go(2, 1'b1);
      step("rs_again", 5, 0, 1, 0, 0);
      step("rs_again", 10, 1, 1, 0, 0);
      bus.stop = 1'b1;
      step("rs_stop", 10, 1, 0, 0, 0);

      // Same-cycle write and start reads the old entry.
      bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 4'd3;
      go(2, 1'b1);
      step("wr_start", 5, 0, 1, 0, 0);
      step("wr_start", 10, 1, 1, 0, 0);
      step("wr_start", 15, 2, 1, 0, 0);
      step("wr_start_new", 3, 0, 1, 0, 0);

      // Reset mid-run clears outputs and the table.
      rst_n = 1'b0;
      step("rst_mid", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step("rst_idle", 0, 0, 0, 0, 0);
      go(2, 1'b1);
      step("rst_tbl", 0, 0, 1, 0, 0);
      step("rst_tbl", 0, 1, 1, 0, 0);
      bus.stop = 1'b1;
      step("rst_stop", 0, 1, 0, 0, 0);

`ifdef SEQ_CTRL_PRESCALE_EN
      // Each value held prescale+1 = 3 cycles.
      for (int a = 0; a < 7; a++) wr("t6_wr", a, t1_tab[a], 0, 1);
      bus.prescale = 8'd2;
      go(6, 1'b1);
      for (int k = 0; k < 24; k++)
         step("t6_psc", t1_tab[(k / 3) % 7], (k / 3) % 7, 1, 0, 0);
      bus.stop = 1'b1;
      step("t6_stop", 2, 0, 0, 0, 0);
`endif

      @(posedge clk);
      #3;
      check_val("drain", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
